// File: rtl/sub_serial_clk.sv
// sub_serial_clk: multi-cycle registered subtractor, d = a - b - bi.
// The borrow ripples one CHUNK-wide slice per clock through a borrow
// register, so no combinational borrow path spans more than CHUNK bits.
// Outputs d/bo/ovf are separate from the working registers and only
// update on the edge that completes an operation.
module sub_serial_clk #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bo_q, bo_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               last;
    logic [CHUNK:0]     chunk_sub;
    int                 idx;

    // A new operation is taken whenever we are not mid-run; start in RUN is dropped
    always_comb begin
        accept = start && (state_q != RUN);
        last   = (cnt_q == CNT_W'(N - 1));
    end

    // State, working and output registers; async reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bo_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bo_q     <= bo_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic: IDLE -> RUN for N cycles -> DONE for one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: one slice of a - b - borrow per RUN cycle, publish on the last slice
    always_comb begin
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        d_d       = d_q;
        bo_d      = bo_q;
        ovf_d     = ovf_q;
        idx       = int'(cnt_q) * CHUNK;
        chunk_sub = {1'b0, a_q[idx +: CHUNK]} - {1'b0, b_q[idx +: CHUNK]}
                    - {{CHUNK{1'b0}}, borrow_q};
        if (accept) begin
            a_d      = a;
            b_d      = b;
            borrow_d = bi;
            cnt_d    = '0;
            diff_d   = '0;
        end else if (state_q == RUN) begin
            diff_d[idx +: CHUNK] = chunk_sub[CHUNK-1:0];
            borrow_d             = chunk_sub[CHUNK];
            cnt_d                = cnt_q + CNT_W'(1);
            if (last) begin
                d_d   = diff_d;
                bo_d  = chunk_sub[CHUNK];
                // Overflow only possible when operand signs differ and the
                // result sign departs from the minuend's sign
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
            end
        end
    end

    // Status flags decode straight from the state; results come from output registers
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        d    = d_q;
        bo   = bo_q;
        ovf  = ovf_q;
    end

endmodule
